// File: rtl/pipe_skid_register_if.sv
// Valid/ready handshake bundle carrying one WIDTH-bit payload.
//   valid : producer presents data
//   ready : consumer can accept data this cycle
//   data  : payload
// master drives valid/data and observes ready; slave is the reverse.
interface pipe_skid_register_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_register.sv
// Pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Breaks the combinational ready path: in_if.ready comes straight from a flop,
// yet a new word can be accepted every cycle while downstream keeps up.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   flush     : drop every held entry
//   in_if     : upstream handshake (slave)
//   out_if    : downstream handshake (master), data driven from the main register
//   occupancy : number of held entries, 0..2
module pipe_skid_register #(
    parameter int unsigned      WIDTH      = 16,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    pipe_skid_register_if.slave  in_if,
    pipe_skid_register_if.master out_if,
    output logic [1:0]           occupancy
);

    // State bit 0 is main_v, bit 1 is skid_v; skid without main is unreachable.
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] FULL  = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic [1:0]       occupancy_q, occupancy_d;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_if.valid & in_ready_q;
    assign out_fire = state_q[0] & out_if.ready;

    // Next state, payload moves and registered status outputs.
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        in_ready_d  = in_ready_q;
        occupancy_d = occupancy_q;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_if.data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_if.data;
                end else if (in_fire) begin
                    skid_d  = in_if.data;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Squash: empty the buffer, leave payload registers untouched.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end

        in_ready_d = ~state_d[1];
        case (state_d)
            ONE:     occupancy_d = 2'd1;
            FULL:    occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

    // State and payload registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= RESET_DATA;
            skid_q      <= RESET_DATA;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = state_q[0];
    assign out_if.data  = main_q;
    assign occupancy    = occupancy_q;

endmodule
